if_id_buffer: RTL and testbench

//  Fetch/decode pipeline register placed directly after the instruction fetch stage.

---
 rtl/if_id_buffer.sv | 118 +++++++++++
 tb/tb_if_id_buffer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/if_id_buffer.sv
// Fetch/decode pipeline register; pairs opcode words with their trailing immediate word.
// Latency: 1 cycle after the plain word, or 1 cycle after the immediate word.
// Backpressure: stall freezes all state and outputs; flush overrides stall and injects a bubble.
module if_id_buffer #(
    parameter int                  INSTR_W      = 16,
    parameter int                  PC_W         = 32,
    parameter logic [INSTR_W-1:0]  NOP_OPCODE   = 16'h4000,
    parameter int                  IMM_FLAG_BIT = 13
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [INSTR_W-1:0] if_instruction,
    input  logic [PC_W-1:0]    if_pc_plus_one,
    input  logic               if_valid,
    input  logic               stall,
    input  logic               flush,
    output logic [INSTR_W-1:0] id_instruction,
    output logic [INSTR_W-1:0] id_immediate,
    output logic [PC_W-1:0]    id_pc_plus_one,
    output logic               id_has_imm,
    output logic               id_valid,
    output logic               imm_pending
);

    typedef enum logic {
        S_OP  = 1'b0,
        S_IMM = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [INSTR_W-1:0] pend_instr_q, pend_instr_d;

    logic [INSTR_W-1:0] instr_d;
    logic [INSTR_W-1:0] imm_d;
    logic [PC_W-1:0]    pc_d;
    logic               has_imm_d;
    logic               valid_d;

    assign imm_pending = (state_q == S_IMM);

    // Next-state and next-output decode; bubble values are the defaults so the
    // undefined fetch pc+1 never reaches decode on a non-instruction cycle.
    always_comb begin
        state_d      = state_q;
        pend_instr_d = pend_instr_q;
        instr_d      = NOP_OPCODE;
        imm_d        = '0;
        pc_d         = '0;
        has_imm_d    = 1'b0;
        valid_d      = 1'b0;
        case (state_q)
            S_OP: begin
                if (if_valid && (if_instruction != NOP_OPCODE)) begin
                    if (if_instruction[IMM_FLAG_BIT]) begin
                        pend_instr_d = if_instruction;
                        state_d      = S_IMM;
                    end else begin
                        instr_d = if_instruction;
                        pc_d    = if_pc_plus_one;
                        valid_d = 1'b1;
                    end
                end
            end
            S_IMM: begin
                // The immediate word is raw data: flag bit and NOP encoding are not inspected.
                if (if_valid) begin
                    instr_d   = pend_instr_q;
                    imm_d     = if_instruction;
                    pc_d      = if_pc_plus_one;
                    has_imm_d = 1'b1;
                    valid_d   = 1'b1;
                    state_d   = S_OP;
                end
            end
            default: begin
                state_d = S_OP;
            end
        endcase
    end

    // FSM state and pending opcode: flush drops the pending opcode, stall holds it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_OP;
            pend_instr_q <= '0;
        end else if (flush) begin
            state_q      <= S_OP;
            pend_instr_q <= '0;
        end else if (!stall) begin
            state_q      <= state_d;
            pend_instr_q <= pend_instr_d;
        end
    end

    // Decode slot registers: flush loads a bubble, stall holds the current slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            id_instruction <= NOP_OPCODE;
            id_immediate   <= '0;
            id_pc_plus_one <= '0;
            id_has_imm     <= 1'b0;
            id_valid       <= 1'b0;
        end else if (flush) begin
            id_instruction <= NOP_OPCODE;
            id_immediate   <= '0;
            id_pc_plus_one <= '0;
            id_has_imm     <= 1'b0;
            id_valid       <= 1'b0;
        end else if (!stall) begin
            id_instruction <= instr_d;
            id_immediate   <= imm_d;
            id_pc_plus_one <= pc_d;
            id_has_imm     <= has_imm_d;
            id_valid       <= valid_d;
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
// Bench for if_id_buffer: directed vectors feed an expectation queue; a monitor
// pops and compares every freshly loaded valid decode slot.
// Bubble/pending/reset behaviour is checked directly from the stimulus process.
module tb_if_id_buffer;

    logic        clk;
    logic        reset_n;
    logic [15:0] if_instruction;
    logic [31:0] if_pc_plus_one;
    logic        if_valid;
    logic        stall;
    logic        flush;
    logic [15:0] id_instruction;
    logic [15:0] id_immediate;
    logic [31:0] id_pc_plus_one;
    logic        id_has_imm;
    logic        id_valid;
    logic        imm_pending;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] imm;
        logic [31:0] pc;
        logic        has_imm;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic upd    = 1'b0;

    if_id_buffer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .if_instruction (if_instruction),
        .if_pc_plus_one (if_pc_plus_one),
        .if_valid       (if_valid),
        .stall          (stall),
        .flush          (flush),
        .id_instruction (id_instruction),
        .id_immediate   (id_immediate),
        .id_pc_plus_one (id_pc_plus_one),
        .id_has_imm     (id_has_imm),
        .id_valid       (id_valid),
        .imm_pending    (imm_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_slot(input logic [15:0] instr, input logic [15:0] imm,
                               input logic [31:0] pc, input logic has_imm);
        exp_t e;
        e.instr   = instr;
        e.imm     = imm;
        e.pc      = pc;
        e.has_imm = has_imm;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs, then return 1 time unit after the loading edge.
    task automatic cycle(input logic [15:0] w, input logic [31:0] pc, input logic v,
                         input logic st, input logic fl);
        if_instruction = w;
        if_pc_plus_one = pc;
        if_valid       = v;
        stall          = st;
        flush          = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic check_bubble(input string name);
        check({name, "_valid"}, {31'd0, id_valid}, 32'd0);
        check({name, "_instr"}, {16'd0, id_instruction}, 32'h4000);
        check({name, "_pc"}, id_pc_plus_one, 32'd0);
    endtask

    // An output slot is fresh only if the edge that produced it was not stalled.
    always @(posedge clk) upd <= !stall;

    // Monitor: compare each freshly loaded valid slot against the queue head.
    always @(negedge clk) begin
        if (reset_n && upd && id_valid) begin
            if (exp_q.size() == 0) begin
                check("mon_unexpected_valid", {31'd0, id_valid}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("mon_instr", {16'd0, id_instruction}, {16'd0, e.instr});
                check("mon_imm", {16'd0, id_immediate}, {16'd0, e.imm});
                check("mon_pc", id_pc_plus_one, e.pc);
                check("mon_has_imm", {31'd0, id_has_imm}, {31'd0, e.has_imm});
            end
        end
    end

    initial begin
        reset_n        = 1'b0;
        if_instruction = 16'h4000;
        if_pc_plus_one = 32'd0;
        if_valid       = 1'b0;
        stall          = 1'b0;
        flush          = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_bubble("reset");
        check("reset_imm", {16'd0, id_immediate}, 32'd0);
        check("reset_has_imm", {31'd0, id_has_imm}, 32'd0);
        check("reset_pending", {31'd0, imm_pending}, 32'd0);
        reset_n = 1'b1;

        // Plain instruction.
        expect_slot(16'h1234, 16'h0000, 32'h21, 1'b0);
        cycle(16'h1234, 32'h21, 1'b1, 1'b0, 1'b0);
        check("plain_valid", {31'd0, id_valid}, 32'd1);
        check("plain_pending", {31'd0, imm_pending}, 32'd0);

        // Stall holds a valid slot unchanged.
        cycle(16'h0555, 32'h99, 1'b1, 1'b1, 1'b0);
        cycle(16'h0666, 32'h98, 1'b1, 1'b1, 1'b0);
        check("stall_hold_instr", {16'd0, id_instruction}, 32'h1234);
        check("stall_hold_pc", id_pc_plus_one, 32'h21);
        check("stall_hold_valid", {31'd0, id_valid}, 32'd1);

        // NOP word with garbage pc+1 must produce a clean bubble.
        cycle(16'h4000, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
        check_bubble("nop_word");
        // Real word without if_valid is ignored.
        cycle(16'h1234, 32'h55, 1'b0, 1'b0, 1'b0);
        check_bubble("invalid_word");

        // Two-word instruction.
        cycle(16'h2ABC, 32'h22, 1'b1, 1'b0, 1'b0);
        check("imm_first_pending", {31'd0, imm_pending}, 32'd1);
        check_bubble("imm_first");
        expect_slot(16'h2ABC, 16'h00FF, 32'h23, 1'b1);
        cycle(16'h00FF, 32'h23, 1'b1, 1'b0, 1'b0);
        check("imm_second_pending", {31'd0, imm_pending}, 32'd0);
        check("imm_second_valid", {31'd0, id_valid}, 32'd1);

        // Fetch gap while waiting for the immediate.
        cycle(16'h2ABC, 32'h2F, 1'b1, 1'b0, 1'b0);
        cycle(16'h7777, 32'h1111, 1'b0, 1'b0, 1'b0);
        check("gap_pending", {31'd0, imm_pending}, 32'd1);
        check_bubble("gap");
        expect_slot(16'h2ABC, 16'h0011, 32'h30, 1'b1);
        cycle(16'h0011, 32'h30, 1'b1, 1'b0, 1'b0);

        // Stall for three cycles mid-pair, then a NOP-valued immediate.
        cycle(16'h2ABC, 32'h40, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(16'h4000, 32'h41, 1'b1, 1'b1, 1'b0);
            check("stall_pending", {31'd0, imm_pending}, 32'd1);
            check("stall_valid", {31'd0, id_valid}, 32'd0);
        end
        expect_slot(16'h2ABC, 16'h4000, 32'h41, 1'b1);
        cycle(16'h4000, 32'h41, 1'b1, 1'b0, 1'b0);
        check("nop_imm_valid", {31'd0, id_valid}, 32'd1);

        // Flush wins over stall and drops the pending opcode.
        cycle(16'h2ABC, 32'h50, 1'b1, 1'b0, 1'b0);
        cycle(16'h00AA, 32'h51, 1'b1, 1'b1, 1'b1);
        check("flush_pending", {31'd0, imm_pending}, 32'd0);
        check_bubble("flush");
        expect_slot(16'h1234, 16'h0000, 32'h52, 1'b0);
        cycle(16'h1234, 32'h52, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle while a pair is pending.
        expect_slot(16'h0777, 16'h0000, 32'h61, 1'b0);
        cycle(16'h0777, 32'h61, 1'b1, 1'b0, 1'b0);
        cycle(16'h2ABC, 32'h62, 1'b1, 1'b0, 1'b0);
        check("pre_reset_pending", {31'd0, imm_pending}, 32'd1);
        #3;
        reset_n = 1'b0;
        #1;
        check_bubble("async_reset");
        check("async_reset_pending", {31'd0, imm_pending}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        // Pending opcode lost: next word decodes as a plain instruction.
        expect_slot(16'h00FF, 16'h0000, 32'h70, 1'b0);
        cycle(16'h00FF, 32'h70, 1'b1, 1'b0, 1'b0);
        check("after_reset_has_imm", {31'd0, id_has_imm}, 32'd0);

        cycle(16'h4000, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
